// File: rtl/nn_pkg.sv
// Shared definitions for the neural-net datapath blocks: sequencer state encoding and the
// field layout of packed weight-ROM words {shift, bias, weights}.
package nn_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} feeder_state_e;

    localparam int unsigned BIAS_W  = 32;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned WT_LSB  = 0;

    function automatic int unsigned bias_lsb(input int unsigned ic, input int unsigned n);
        return ic * n;
    endfunction

    function automatic int unsigned shift_lsb(input int unsigned ic, input int unsigned n);
        return ic * n + BIAS_W;
    endfunction

endpackage

// File: rtl/pconv_addr_gen.sv
// Nested output-channel / pixel counters for the pointwise-conv feeder; pixel is the inner
// loop, and last_o flags the final (oc, pix) pair of a pass.
module pconv_addr_gen #(
    parameter int unsigned OUTPUT_CHANNEL = 8,
    parameter int unsigned PIXELS         = 784,
    parameter int unsigned PA_W           = 10,
    parameter int unsigned OA_W           = 3
) (
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic            ce_i,
    input  logic            adv_i,
    output logic [PA_W-1:0] pix_o,
    output logic [OA_W-1:0] oc_o,
    output logic            last_o
);

    localparam logic [PA_W-1:0] PixLast = PA_W'(PIXELS - 1);
    localparam logic [OA_W-1:0] OcLast  = OA_W'(OUTPUT_CHANNEL - 1);

    logic [PA_W-1:0] pix_q;
    logic [OA_W-1:0] oc_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            pix_q <= '0;
            oc_q  <= '0;
        end else if (ce_i && adv_i) begin
            if (pix_q == PixLast) begin
                pix_q <= '0;
                oc_q  <= (oc_q == OcLast) ? '0 : oc_q + 1'b1;
            end else begin
                pix_q <= pix_q + 1'b1;
            end
        end
    end

    assign pix_o  = pix_q;
    assign oc_o   = oc_q;
    assign last_o = (pix_q == PixLast) && (oc_q == OcLast);

endmodule

// File: rtl/pconv_feeder.sv
// Sequencer feeding pconv_unit: walks every (oc, pix) pair, issues feature-RAM and weight-ROM
// reads, and presents one beat per enabled cycle one stage behind the reads.
module pconv_feeder
    import nn_pkg::*;
#(
    parameter int unsigned N              = 16,
    parameter int unsigned INPUT_CHANNEL  = 3,
    parameter int unsigned OUTPUT_CHANNEL = 8,
    parameter int unsigned PIXELS         = 784,
    parameter int unsigned PA_W           = 10,
    parameter int unsigned OA_W           = 3
) (
    input  logic                          clk_i,
    input  logic                          rst_n,
    input  logic                          ce_i,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          fm_rd_en_o,
    output logic [PA_W-1:0]               fm_rd_addr_o,
    input  logic [INPUT_CHANNEL*N-1:0]    fm_rd_data_i,
    output logic                          wt_rd_en_o,
    output logic [OA_W-1:0]               wt_rd_addr_o,
    input  logic [INPUT_CHANNEL*N+36:0]   wt_rd_data_i,
    output logic                          input_vld_o,
    output logic [INPUT_CHANNEL*N-1:0]    input_din_o,
    output logic [INPUT_CHANNEL*N-1:0]    weight_din_o,
    output logic [BIAS_W-1:0]             bias_dout_o,
    output logic [SHIFT_W-1:0]            shift_dout_o,
    output logic [OA_W-1:0]               oc_idx_o,
    output logic [PA_W-1:0]               pix_idx_o
);

    localparam int unsigned DataW    = INPUT_CHANNEL * N;
    localparam int unsigned BiasLsb  = bias_lsb(INPUT_CHANNEL, N);
    localparam int unsigned ShiftLsb = shift_lsb(INPUT_CHANNEL, N);

    feeder_state_e   state_q;
    logic            busy_q, done_q, vld_q;
    logic [OA_W-1:0] oc_idx_q;
    logic [PA_W-1:0] pix_idx_q;
    logic [PA_W-1:0] pix;
    logic [OA_W-1:0] oc;
    logic            last, run, issue;

    assign run   = (state_q == StRun);
    assign issue = run && ce_i;

    pconv_addr_gen #(
        .OUTPUT_CHANNEL(OUTPUT_CHANNEL),
        .PIXELS        (PIXELS),
        .PA_W          (PA_W),
        .OA_W          (OA_W)
    ) u_addr_gen (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .ce_i  (ce_i),
        .adv_i (run),
        .pix_o (pix),
        .oc_o  (oc),
        .last_o(last)
    );

    // DONE always returns to IDLE so the done pulse is exactly one cycle wide.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (state_q == StDone) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
        end else if (ce_i) begin
            case (state_q)
                StIdle: if (start_i) begin
                    state_q <= StRun;
                    busy_q  <= 1'b1;
                end
                StRun: if (last) state_q <= StDrain;
                StDrain: begin
                    state_q <= StDone;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // The memories' output registers are the data half of the beat stage; here we only carry
    // the valid flag and the (oc, pix) tag alongside them.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            vld_q     <= 1'b0;
            oc_idx_q  <= '0;
            pix_idx_q <= '0;
        end else if (ce_i) begin
            vld_q <= run;
            if (run) begin
                oc_idx_q  <= oc;
                pix_idx_q <= pix;
            end
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign fm_rd_en_o   = issue;
    assign fm_rd_addr_o = pix;
    assign wt_rd_en_o   = issue && (pix == '0);
    assign wt_rd_addr_o = oc;

    assign input_vld_o  = vld_q && ce_i;
    assign input_din_o  = vld_q ? fm_rd_data_i : '0;
    assign weight_din_o = vld_q ? wt_rd_data_i[WT_LSB +: DataW] : '0;
    assign bias_dout_o  = vld_q ? wt_rd_data_i[BiasLsb +: BIAS_W] : '0;
    assign shift_dout_o = vld_q ? wt_rd_data_i[ShiftLsb +: SHIFT_W] : '0;
    assign oc_idx_o     = oc_idx_q;
    assign pix_idx_o    = pix_idx_q;

endmodule

// File: tb/tb_pconv_feeder.sv
// Randomized bench for pconv_feeder: a 2x4 instance exercised with ce bubbles, ignored starts
// and mid-pass reset, plus a 1x1 instance for the degenerate pass.
module tb_pconv_feeder;

    localparam int unsigned OC    = 2;
    localparam int unsigned PIX   = 4;
    localparam int unsigned TOTAL = OC * PIX;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- main instance (OC=2, PIXELS=4) ----------------
    logic        rst_n, ce, start;
    logic        busy, done, fm_rd_en, wt_rd_en, input_vld;
    logic [9:0]  fm_rd_addr, pix_idx;
    logic [2:0]  wt_rd_addr, oc_idx;
    logic [47:0] fm_q, input_din, weight_din;
    logic [84:0] wt_q;
    logic [31:0] bias_dout;
    logic [4:0]  shift_dout;

    logic [47:0] ram [PIX];
    logic [84:0] rom [OC];

    always @(posedge clk) begin
        if (fm_rd_en) fm_q <= ram[fm_rd_addr[1:0]];
        if (wt_rd_en) wt_q <= rom[wt_rd_addr[0]];
    end

    pconv_feeder #(
        .N(16), .INPUT_CHANNEL(3), .OUTPUT_CHANNEL(OC), .PIXELS(PIX), .PA_W(10), .OA_W(3)
    ) dut (
        .clk_i(clk), .rst_n(rst_n), .ce_i(ce), .start_i(start), .busy_o(busy), .done_o(done),
        .fm_rd_en_o(fm_rd_en), .fm_rd_addr_o(fm_rd_addr), .fm_rd_data_i(fm_q),
        .wt_rd_en_o(wt_rd_en), .wt_rd_addr_o(wt_rd_addr), .wt_rd_data_i(wt_q),
        .input_vld_o(input_vld), .input_din_o(input_din), .weight_din_o(weight_din),
        .bias_dout_o(bias_dout), .shift_dout_o(shift_dout), .oc_idx_o(oc_idx),
        .pix_idx_o(pix_idx)
    );

    // ---------------- degenerate instance (OC=1, PIXELS=1) ----------------
    logic        d_ce, d_start, d_busy, d_done, d_fm_rd_en, d_wt_rd_en, d_input_vld;
    logic [0:0]  d_fm_rd_addr, d_pix_idx, d_wt_rd_addr, d_oc_idx;
    logic [47:0] d_fm_q, d_input_din, d_weight_din, d_ram;
    logic [84:0] d_wt_q, d_rom;
    logic [31:0] d_bias_dout;
    logic [4:0]  d_shift_dout;

    always @(posedge clk) begin
        if (d_fm_rd_en) d_fm_q <= d_ram;
        if (d_wt_rd_en) d_wt_q <= d_rom;
    end

    pconv_feeder #(
        .N(16), .INPUT_CHANNEL(3), .OUTPUT_CHANNEL(1), .PIXELS(1), .PA_W(1), .OA_W(1)
    ) dut_deg (
        .clk_i(clk), .rst_n(rst_n), .ce_i(d_ce), .start_i(d_start), .busy_o(d_busy),
        .done_o(d_done), .fm_rd_en_o(d_fm_rd_en), .fm_rd_addr_o(d_fm_rd_addr),
        .fm_rd_data_i(d_fm_q), .wt_rd_en_o(d_wt_rd_en), .wt_rd_addr_o(d_wt_rd_addr),
        .wt_rd_data_i(d_wt_q), .input_vld_o(d_input_vld), .input_din_o(d_input_din),
        .weight_din_o(d_weight_din), .bias_dout_o(d_bias_dout), .shift_dout_o(d_shift_dout),
        .oc_idx_o(d_oc_idx), .pix_idx_o(d_pix_idx)
    );

    task automatic fill_mems(input bit fixed_fields);
        for (int i = 0; i < int'(PIX); i++) ram[i] = 48'({$urandom(), $urandom()});
        for (int i = 0; i < int'(OC); i++)
            rom[i] = {5'($urandom()), $urandom(), 48'({$urandom(), $urandom()})};
        if (fixed_fields) begin
            rom[1][84:80] = 5'h1F;
            rom[1][79:48] = 32'h8000_0001;
        end
    endtask

    task automatic check_all_zero();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_vld", input_vld, 0);
        check_eq("rst_fm_en", fm_rd_en, 0);
        check_eq("rst_wt_en", wt_rd_en, 0);
        check_eq("rst_din", input_din, 0);
        check_eq("rst_wdin", weight_din, 0);
        check_eq("rst_bias", bias_dout, 0);
        check_eq("rst_shift", shift_dout, 0);
        check_eq("rst_oc_idx", oc_idx, 0);
        check_eq("rst_pix_idx", pix_idx, 0);
        check_eq("rst_fm_addr", fm_rd_addr, 0);
        check_eq("rst_wt_addr", wt_rd_addr, 0);
    endtask

    // mode 0: ce high; 1: two ce-low cycles after the 3rd beat; 2: random ce.
    // Entered and left at posedge+1. Expected order: oc outer, pix inner; each ce-low cycle
    // pushes every later event back by one cycle.
    task automatic run_pass(input int mode, input bit poke, input int abort_at);
        int cyc, beats, lows, fm_n, wt_n, bub, oc_e, pix_e;
        bit fin, aborted;
        cyc = 0; beats = 0; lows = 0; fm_n = 0; wt_n = 0; bub = 2; fin = 0; aborted = 0;
        start = 1'b1;
        ce    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (!fin && cyc < 200) begin
            cyc++;
            case (mode)
                1:       begin ce = !(beats == 3 && bub > 0); if (!ce) bub--; end
                2:       ce = ($urandom_range(0, 3) != 0);
                default: ce = 1'b1;
            endcase
            start = poke && (cyc == 4);
            #1;
            if (fm_rd_en) begin
                check_eq("fm_addr", fm_rd_addr, fm_n % PIX);
                fm_n++;
            end
            if (wt_rd_en) begin
                check_eq("wt_addr", wt_rd_addr, wt_n);
                wt_n++;
            end
            if (!ce) check_eq("vld_ce_low", input_vld, 0);
            if (input_vld) begin
                check_eq("beat_cycle", cyc, beats + 2 + lows);
                check_eq("beat_busy", busy, 1);
                if (beats < int'(TOTAL)) begin
                    oc_e  = beats / PIX;
                    pix_e = beats % PIX;
                    check_eq("oc_idx", oc_idx, oc_e);
                    check_eq("pix_idx", pix_idx, pix_e);
                    check_eq("input_din", input_din, ram[pix_e]);
                    check_eq("weight_din", weight_din, rom[oc_e][47:0]);
                    check_eq("bias_dout", bias_dout, rom[oc_e][79:48]);
                    check_eq("shift_dout", shift_dout, rom[oc_e][84:80]);
                end else begin
                    check_eq("beat_count", beats + 1, TOTAL);
                end
                beats++;
                if (abort_at > 0 && beats == abort_at) begin
                    fin = 1;
                    aborted = 1;
                end
            end
            if (done && !aborted) begin
                check_eq("done_cycle", cyc, TOTAL + 2 + lows);
                check_eq("beats_at_done", beats, TOTAL);
                check_eq("busy_at_done", busy, 0);
                check_eq("fm_reads", fm_n, TOTAL);
                check_eq("wt_reads", wt_n, OC);
                fin = 1;
            end else if (!aborted) begin
                check_eq("busy_in_pass", busy, 1);
            end
            if (!ce) lows++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (!fin) check_eq("done_timeout", done, 1);
        if (aborted) begin
            rst_n = 1'b0;
            ce    = 1'b1;
            @(posedge clk); #1;
            rst_n = 1'b1;
            #1;
            check_all_zero();
            @(posedge clk); #1;
        end else begin
            ce = 1'b1;
            #1;
            check_eq("done_one_cycle", done, 0);
            check_eq("idle_busy", busy, 0);
            check_eq("idle_vld", input_vld, 0);
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                check_eq("no_extra_done", done, 0);
                check_eq("no_extra_vld", input_vld, 0);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic run_degenerate();
        int fm_n, wt_n, beats, dones;
        fm_n = 0; wt_n = 0; beats = 0; dones = 0;
        d_ram = 48'({$urandom(), $urandom()});
        d_rom = {5'($urandom()), $urandom(), 48'({$urandom(), $urandom()})};
        d_start = 1'b1;
        @(posedge clk); #1;
        d_start = 1'b0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            #1;
            if (d_fm_rd_en) begin
                fm_n++;
                check_eq("deg_fm_cycle", cyc, 1);
            end
            if (d_wt_rd_en) wt_n++;
            if (d_input_vld) begin
                beats++;
                check_eq("deg_beat_cycle", cyc, 2);
                check_eq("deg_din", d_input_din, d_ram);
                check_eq("deg_wdin", d_weight_din, d_rom[47:0]);
                check_eq("deg_bias", d_bias_dout, d_rom[79:48]);
                check_eq("deg_shift", d_shift_dout, d_rom[84:80]);
            end
            if (d_done) begin
                dones++;
                check_eq("deg_done_cycle", cyc, 3);
            end
            @(posedge clk); #1;
        end
        check_eq("deg_fm_reads", fm_n, 1);
        check_eq("deg_wt_reads", wt_n, 1);
        check_eq("deg_beats", beats, 1);
        check_eq("deg_dones", dones, 1);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; start = 1'b0; d_ce = 1'b1; d_start = 1'b0;
        fill_mems(1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_all_zero();
        @(posedge clk); #1;

        run_pass(0, 1'b0, 0);                         // nominal, fixed bias/shift in oc1
        check_eq("field_bias", rom[1][79:48], 32'h8000_0001);
        fill_mems(1'b1);
        run_pass(1, 1'b0, 0);                         // ce bubble
        fill_mems(1'b0);
        run_pass(0, 1'b1, 0);                         // start during RUN is ignored
        fill_mems(1'b0);
        run_pass(0, 1'b0, 5);                         // reset after beat 5
        run_pass(0, 1'b0, 0);                         // fresh pass from (0,0)
        for (int i = 0; i < 4; i++) begin
            fill_mems(i[0]);
            run_pass(2, 1'b0, 0);
        end
        run_degenerate();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
